// File: rtl/core_bram_reader_pkg.sv
// ----------------------------------------------------------------------------
// core_bram_reader_pkg
// Shared types and constants for the BRAM stream reader and its FIFO.
//   reader_state_e : reader control states (IDLE, READ, DRAIN)
//   FifoDepth      : number of entries in the output skid FIFO
//   FifoCntWidth   : width of the FIFO occupancy count
//   StallCntWidth  : width of the optional stall counter
//                    (CORE_BRAM_READER_STALL_CNT_EN)
// ----------------------------------------------------------------------------
package core_bram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

  localparam int FifoDepth     = 2;
  localparam int FifoCntWidth  = $clog2(FifoDepth + 1);
  localparam int StallCntWidth = 32;

endpackage : core_bram_reader_pkg

// File: rtl/core_fifo2.sv
// ----------------------------------------------------------------------------
// core_fifo2
// Two-entry FIFO holding {last, data} beats between the BRAM return path and
// the output stream. The head entry is presented combinationally.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, wdata_i : write strobe and entry
//   pop_i           : remove head entry
//   rdata_o         : head entry
//   count_o         : occupancy (0..2)
//   full_o, empty_o : occupancy flags
// ----------------------------------------------------------------------------
module core_fifo2
  import core_bram_reader_pkg::*;
#(
  parameter int Width = 9
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [Width-1:0]        wdata_i,
  output logic [Width-1:0]        rdata_o,
  output logic [FifoCntWidth-1:0] count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  logic [Width-1:0]        mem_q [FifoDepth];
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [FifoCntWidth-1:0] count_q;
  logic                    do_push;
  logic                    do_pop;

  // A push into a full FIFO is only honoured when the head leaves in the same
  // cycle; the slot being written is then the one just vacated.
  always_comb begin
    full_o  = (count_q == FifoCntWidth'(FifoDepth));
    empty_o = (count_q == '0);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || pop_i);
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + FifoCntWidth'(1);
        2'b01:   count_q <= count_q - FifoCntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : core_fifo2

// File: rtl/core_bram_stream_reader.sv
// ----------------------------------------------------------------------------
// core_bram_stream_reader
// Burst read initiator for one port of a synchronous (1-cycle latency) BRAM.
// A command (base, length) produces `length` sequential reads, wrapping at
// Depth, and the returned words leave as a valid/ready stream with last_o on
// the final beat. A 2-entry FIFO plus a credit check absorbs the read latency
// so backpressure never loses a beat.
// Optional feature macro: CORE_BRAM_READER_STALL_CNT_EN adds stall_cnt_o.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i                : command strobe (IDLE only)
//   base_addr_i, length_i  : burst start address and word count
//   busy_o, done_o         : burst in progress / one-cycle completion pulse
//   bram_addr_o            : BRAM read address
//   bram_write_en_o        : BRAM write enable (always 0)
//   bram_wdata_o           : BRAM write data (always 0)
//   bram_rdata_i           : BRAM read data
//   data_o, valid_o,
//   ready_i, last_o        : output stream
//   stall_cnt_o            : valid-without-ready cycles (optional)
// ----------------------------------------------------------------------------
module core_bram_stream_reader
  import core_bram_reader_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int Depth     = 1024,
  parameter int AddrWidth = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] length_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AddrWidth-1:0] bram_addr_o,
  output logic                 bram_write_en_o,
  output logic [DataWidth-1:0] bram_wdata_o,
  input  logic [DataWidth-1:0] bram_rdata_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o
`ifdef CORE_BRAM_READER_STALL_CNT_EN
  ,
  output logic [StallCntWidth-1:0] stall_cnt_o
`endif
);

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  reader_state_e           state_q, state_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [AddrWidth-1:0]    len_q, len_d;
  logic [AddrWidth-1:0]    issued_q, issued_d;
  logic [AddrWidth-1:0]    hold_q, hold_d;
  logic                    inflight_q, inflight_d;
  logic                    inflight_last_q, inflight_last_d;
  logic                    zero_done_q, zero_done_d;

  logic                    issue;
  logic                    accept;
  logic                    drain_done;
  logic                    last_issue;
  logic                    pop;
  logic                    credit_ok;
  logic [2:0]              occ;
  logic [2:0]              limit;

  logic [DataWidth:0]      fifo_rdata;
  logic [FifoCntWidth-1:0] fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;

  // Beats return one cycle after issue; the in-flight flag is the push strobe
  // and carries the last tag alongside the data.
  core_fifo2 #(
    .Width(DataWidth + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .wdata_i ({inflight_last_q, bram_rdata_i}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Stream side: a beat is valid whenever the FIFO holds one.
  always_comb begin
    valid_o         = !fifo_empty;
    data_o          = fifo_rdata[DataWidth-1:0];
    last_o          = valid_o && fifo_rdata[DataWidth];
    pop             = valid_o && ready_i;
    bram_write_en_o = 1'b0;
    bram_wdata_o    = '0;
  end

  // Credit check: a new read may issue only if, after this cycle's pop, the
  // FIFO plus the read already in flight leave room for it.
  always_comb begin
    occ        = {1'b0, fifo_count} + {2'b0, inflight_q};
    limit      = 3'(FifoDepth) + {2'b0, pop};
    credit_ok  = (occ < limit) && !(fifo_full && !pop);
    last_issue = (issued_q == len_q - AddrWidth'(1));
  end

  // Next-state logic for the control FSM and the burst bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    hold_d      = hold_q;
    zero_done_d = 1'b0;
    issue       = 1'b0;
    accept      = 1'b0;
    drain_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !zero_done_q) begin
          if (length_i != '0) begin
            accept   = 1'b1;
            addr_d   = base_addr_i;
            len_d    = length_i;
            issued_d = '0;
            state_d  = READ;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      READ: begin
        if ((issued_q < len_q) && credit_ok) begin
          issue    = 1'b1;
          hold_d   = addr_q;
          addr_d   = (addr_q == LastAddr) ? '0 : addr_q + AddrWidth'(1);
          issued_d = issued_q + AddrWidth'(1);
          if (last_issue) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && fifo_empty) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    inflight_d      = issue;
    inflight_last_d = issue && last_issue;
  end

  // The BRAM address follows the issuing read and otherwise holds.
  always_comb begin
    bram_addr_o = issue ? addr_q : hold_q;
    busy_o      = (state_q != IDLE) && !drain_done;
    done_o      = drain_done || zero_done_q;
  end

  // Control and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      hold_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      hold_q          <= hold_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      zero_done_q     <= zero_done_d;
    end
  end

`ifdef CORE_BRAM_READER_STALL_CNT_EN
  logic [StallCntWidth-1:0] stall_q, stall_d;

  // Saturating count of stalled cycles, restarted by each accepted command
  // and left untouched after the burst ends.
  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if (valid_o && !ready_i && (stall_q != '1)) begin
      stall_d = stall_q + StallCntWidth'(1);
    end
    stall_cnt_o = stall_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

endmodule : core_bram_stream_reader

// File: tb/tb_core_bram_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_core_bram_stream_reader
// Directed bench for core_bram_stream_reader with Depth=16 and a synchronous
// BRAM model holding memory[i] = i + 0x40. Inputs change 1 time unit after
// the rising edge; outputs are checked 1 time unit later in the same cycle.
// ----------------------------------------------------------------------------
module tb_core_bram_stream_reader;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 5;

  logic          clk;
  logic          rstN;
  logic          startIn;
  logic [AW-1:0] baseAddr;
  logic [AW-1:0] lengthIn;
  logic          busy;
  logic          done;
  logic [AW-1:0] bramAddr;
  logic          bramWriteEn;
  logic [DW-1:0] bramWdata;
  logic [DW-1:0] bramRdata;
  logic [DW-1:0] dataOut;
  logic          validOut;
  logic          readyIn;
  logic          lastOut;
`ifdef CORE_BRAM_READER_STALL_CNT_EN
  logic [31:0]   stallCnt;
`endif

  logic [DW-1:0] mem [DEPTH];

  int checkCount;
  int errorCount;

  logic          readyPat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [DW-1:0] bpData   [7] = '{8'h4A, 8'h4B, 8'h4B, 8'h4B, 8'h4C, 8'h4C, 8'h4D};
  logic          bpLast   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  core_bram_stream_reader #(
    .DataWidth(DW),
    .Depth    (DEPTH),
    .AddrWidth(AW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .start_i        (startIn),
    .base_addr_i    (baseAddr),
    .length_i       (lengthIn),
    .busy_o         (busy),
    .done_o         (done),
    .bram_addr_o    (bramAddr),
    .bram_write_en_o(bramWriteEn),
    .bram_wdata_o   (bramWdata),
    .bram_rdata_i   (bramRdata),
    .data_o         (dataOut),
    .valid_o        (validOut),
    .ready_i        (readyIn),
    .last_o         (lastOut)
`ifdef CORE_BRAM_READER_STALL_CNT_EN
    ,
    .stall_cnt_o    (stallCnt)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read BRAM: the address seen at an edge is returned after it.
  always @(posedge clk) begin
    bramRdata <= mem[bramAddr[3:0]];
  end

  // Moves to the next cycle and applies that cycle's inputs, leaving time for
  // the combinational outputs to settle before any check.
  task automatic applyStimulus(input logic s, input logic [AW-1:0] b,
                               input logic [AW-1:0] l, input logic r);
    @(posedge clk);
    #1;
    startIn  = s;
    baseAddr = b;
    lengthIn = l;
    readyIn  = r;
    #1;
  endtask

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Checks the stream outputs of the current cycle.
  task automatic checkStream(input string tag, input logic v,
                             input logic [DW-1:0] d, input logic l);
    checkOutput({tag, ".valid"}, 32'(validOut), 32'(v));
    if (v) begin
      checkOutput({tag, ".data"}, 32'(dataOut), 32'(d));
    end
    checkOutput({tag, ".last"}, 32'(lastOut), 32'(l));
  endtask

  // Directed sequence.
  initial begin
    checkCount = 0;
    errorCount = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'(i + 'h40);
    end
    rstN     = 1'b0;
    startIn  = 1'b0;
    baseAddr = '0;
    lengthIn = '0;
    readyIn  = 1'b0;

    #2;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.valid", 32'(validOut), 32'd0);
    checkOutput("reset.last", 32'(lastOut), 32'd0);
    checkOutput("reset.addr", 32'(bramAddr), 32'd0);
    checkOutput("reset.data", 32'(dataOut), 32'd0);
    checkOutput("reset.we", 32'(bramWriteEn), 32'd0);
    checkOutput("reset.wdata", 32'(bramWdata), 32'd0);
    #6;
    rstN = 1'b1;

    $display("[TB] contiguous burst base=10 length=4");
    applyStimulus(1'b1, 5'd10, 5'd4, 1'b1);
    checkOutput("c.c0.busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("c.c1.busy", 32'(busy), 32'd1);
    checkOutput("c.c1.addr", 32'(bramAddr), 32'd10);
    checkStream("c.c1", 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("c.c2", 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("c.c3", 1'b1, 8'h4A, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("c.c4", 1'b1, 8'h4B, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("c.c5", 1'b1, 8'h4C, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("c.c6", 1'b1, 8'h4D, 1'b1);
    checkOutput("c.c6.done", 32'(done), 32'd0);
    checkOutput("c.c6.busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("c.c7.done", 32'(done), 32'd1);
    checkOutput("c.c7.busy", 32'(busy), 32'd0);
    checkStream("c.c7", 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("c.c8.done", 32'(done), 32'd0);

    $display("[TB] backpressure burst base=10 length=4");
    applyStimulus(1'b1, 5'd10, 5'd4, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, readyPat[k]);
      checkStream($sformatf("bp.k%0d", k), 1'b1, bpData[k], bpLast[k]);
      checkOutput($sformatf("bp.k%0d.done", k), 32'(done), 32'd0);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("bp.done", 32'(done), 32'd1);
    checkOutput("bp.busy", 32'(busy), 32'd0);
    checkStream("bp.end", 1'b0, 8'h00, 1'b0);
`ifdef CORE_BRAM_READER_STALL_CNT_EN
    checkOutput("bp.stall", stallCnt, 32'd3);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    checkOutput("bp.stall.hold", stallCnt, 32'd3);
`endif

    $display("[TB] wrap-around burst base=14 length=4");
    applyStimulus(1'b1, 5'd14, 5'd4, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("w.c1.addr", 32'(bramAddr), 32'd14);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("w.c2.addr", 32'(bramAddr), 32'd15);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("w.c3.addr", 32'(bramAddr), 32'd0);
    checkStream("w.c3", 1'b1, 8'h4E, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("w.c4.addr", 32'(bramAddr), 32'd1);
    checkStream("w.c4", 1'b1, 8'h4F, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("w.c5.addr.hold", 32'(bramAddr), 32'd1);
    checkStream("w.c5", 1'b1, 8'h40, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("w.c6", 1'b1, 8'h41, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("w.c7.done", 32'(done), 32'd1);

    $display("[TB] zero-length command");
    applyStimulus(1'b1, 5'd3, 5'd0, 1'b1);
    checkOutput("z.c0.busy", 32'(busy), 32'd0);
    checkOutput("z.c0.done", 32'(done), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("z.c1.done", 32'(done), 32'd1);
    checkOutput("z.c1.busy", 32'(busy), 32'd0);
    checkOutput("z.c1.valid", 32'(validOut), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("z.c2.done", 32'(done), 32'd0);
    checkOutput("z.c2.valid", 32'(validOut), 32'd0);

    $display("[TB] start while busy is ignored");
    applyStimulus(1'b1, 5'd10, 5'd4, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    applyStimulus(1'b1, 5'd0, 5'd2, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("sb.c3", 1'b1, 8'h4A, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("sb.c4", 1'b1, 8'h4B, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("sb.c5", 1'b1, 8'h4C, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("sb.c6", 1'b1, 8'h4D, 1'b1);
    applyStimulus(1'b1, 5'd0, 5'd2, 1'b1);
    checkOutput("sb.c7.done", 32'(done), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("sb.c8.done", 32'(done), 32'd0);
    checkOutput("sb.c8.busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("sb.c9.valid", 32'(validOut), 32'd0);
    checkOutput("sb.c9.done", 32'(done), 32'd0);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(1'b1, 5'd10, 5'd4, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("r.c3", 1'b1, 8'h4A, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("r.c4", 1'b1, 8'h4B, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("r.rst.valid", 32'(validOut), 32'd0);
    checkOutput("r.rst.busy", 32'(busy), 32'd0);
    checkOutput("r.rst.last", 32'(lastOut), 32'd0);
    checkOutput("r.rst.done", 32'(done), 32'd0);
    checkOutput("r.rst.addr", 32'(bramAddr), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("r.held.valid", 32'(validOut), 32'd0);
    checkOutput("r.held.done", 32'(done), 32'd0);
    rstN = 1'b1;
    applyStimulus(1'b1, 5'd3, 5'd2, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("r.n1.addr", 32'(bramAddr), 32'd3);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("r.n2", 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("r.n3", 1'b1, 8'h43, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkStream("r.n4", 1'b1, 8'h44, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1);
    checkOutput("r.n5.done", 32'(done), 32'd1);
    checkOutput("r.n5.busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule : tb_core_bram_stream_reader
